ram_dma_ci: RTL and testbench

- Custom-instruction (CI) block for the processor.
- Contains a 512x32 local SRAM that the CPU accesses directly through CI operations.
- Contains a DMA engine that moves blocks between the SRAM and the shared system bus, in either direction, using burst transactions.
- Responds only when `ciN` matches `customId`; sits beside the CPU as a CI slave and as a bus master.

---
 rtl/ram_dma_ci.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_ram_dma_ci.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dma_ci.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ram_dma_ci
// Description : Custom-instruction slave with a 512x32 local SRAM and a burst
//               DMA engine moving blocks between the SRAM and the system bus.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_dma_ci #(
    parameter logic [7:0] customId = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result,
    output logic        requestTransaction,
    input  logic        transactionGranted,
    input  logic [31:0] addressDataIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    input  logic        busErrorIn,
    input  logic        busyIn,
    output logic [31:0] addressDataOut,
    output logic [3:0]  byteEnablesOut,
    output logic [7:0]  burstSizeOut,
    output logic        readNotWriteOut,
    output logic        beginTransactionOut,
    output logic        endTransactionOut,
    output logic        dataValidOut
);

    localparam logic [2:0] c_FN_SRAM    = 3'd0;
    localparam logic [2:0] c_FN_BUSADDR = 3'd1;
    localparam logic [2:0] c_FN_MEMADDR = 3'd2;
    localparam logic [2:0] c_FN_SIZE    = 3'd3;
    localparam logic [2:0] c_FN_BURST   = 3'd4;
    localparam logic [2:0] c_FN_CTRL    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQUEST  = 3'd1,
        S_INIT     = 3'd2,
        S_READ     = 3'd3,
        S_WRITE    = 3'd4,
        S_WAIT_END = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t r_state, w_state_next;

    // Local SRAM and its two synchronous read ports
    logic [31:0] r_mem [0:511];
    logic [31:0] r_ci_q;
    logic [31:0] r_dma_q;

    // Configuration registers (CI visible)
    logic [31:0] r_bus_addr_cfg;
    logic [8:0]  r_mem_addr_cfg;
    logic [9:0]  r_size_cfg;
    logic [7:0]  r_burst_cfg;

    // Working copies used while a transfer is in progress
    logic [31:0] r_bus_addr;
    logic [8:0]  r_sram_addr;
    logic [9:0]  r_remaining;
    logic [7:0]  r_burst;
    logic [8:0]  r_burst_left;
    logic [8:0]  r_burst_words;
    logic        r_dir_read;
    logic        r_busy;
    logic        r_error;

    // CI response registers
    logic        r_done;
    logic        r_is_mem;
    logic [31:0] r_cfg_q;

    logic        w_accept;
    logic [2:0]  w_func;
    logic        w_we;
    logic [8:0]  w_ci_addr;
    logic        w_cfg_we;
    logic        w_start_dma;
    logic [7:0]  w_burst_m1;
    logic [8:0]  w_burst_words;
    logic        w_dma_we;
    logic        w_word_acc;
    logic        w_burst_end;
    logic        w_abort;
    logic [9:0]  w_rem_after;
    logic [8:0]  w_rd_addr;
    logic        w_unused_ok;

    assign w_accept    = start && (ciN == customId);
    assign w_func      = valueA[12:10];
    assign w_we        = valueA[9];
    assign w_ci_addr   = valueA[8:0];
    assign w_cfg_we    = w_accept && w_we && !r_busy;
    assign w_start_dma = w_cfg_we && (w_func == c_FN_CTRL) &&
                         ((valueB[1:0] == 2'd1) || (valueB[1:0] == 2'd2));
    assign w_abort     = (r_state != S_IDLE) && busErrorIn;
    assign w_unused_ok = &{1'b0, valueA[31:13]};

    // Burst length is the smaller of the remaining words and the configured burst
    assign w_burst_m1    = ({2'b00, r_burst} >= r_remaining) ? 8'(r_remaining - 10'd1) : r_burst;
    assign w_burst_words = {1'b0, w_burst_m1} + 9'd1;
    assign w_rem_after   = dataValidIn ? (r_remaining - 10'd1) : r_remaining;

    // Prefetch: look one word ahead whenever the presented word is taken
    assign w_rd_addr = w_word_acc ? (r_sram_addr + 9'd1) : r_sram_addr;

    // CI result is only driven during the done cycle
    assign done   = r_done;
    assign result = r_done ? (r_is_mem ? r_ci_q : r_cfg_q) : 32'd0;

    // SRAM write ports (DMA write last so it wins a collision) and read ports
    always_ff @(posedge clock) begin
        if (w_accept && w_we && (w_func == c_FN_SRAM)) begin
            r_mem[w_ci_addr] <= valueB;
        end
        if (w_dma_we) begin
            r_mem[r_sram_addr] <= addressDataIn;
        end
        r_ci_q  <= r_mem[w_ci_addr];
        r_dma_q <= r_mem[w_rd_addr];
    end

    // DMA state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // DMA next-state logic and bus outputs
    always_comb begin
        w_state_next        = r_state;
        requestTransaction  = 1'b0;
        addressDataOut      = 32'd0;
        byteEnablesOut      = 4'h0;
        burstSizeOut        = 8'd0;
        readNotWriteOut     = 1'b0;
        beginTransactionOut = 1'b0;
        endTransactionOut   = 1'b0;
        dataValidOut        = 1'b0;
        w_dma_we            = 1'b0;
        w_word_acc          = 1'b0;
        w_burst_end         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_dma) begin
                    w_state_next = (r_size_cfg == 10'd0) ? S_DONE : S_REQUEST;
                end
            end
            S_REQUEST: begin
                requestTransaction = 1'b1;
                if (transactionGranted) begin
                    w_state_next = S_INIT;
                end
            end
            S_INIT: begin
                beginTransactionOut = 1'b1;
                addressDataOut      = r_bus_addr;
                byteEnablesOut      = 4'hF;
                burstSizeOut        = w_burst_m1;
                readNotWriteOut     = r_dir_read;
                w_state_next        = r_dir_read ? S_READ : S_WRITE;
            end
            S_READ: begin
                w_dma_we = dataValidIn;
                if (endTransactionIn) begin
                    w_burst_end  = 1'b1;
                    w_state_next = (w_rem_after == 10'd0) ? S_DONE : S_REQUEST;
                end
            end
            S_WRITE: begin
                dataValidOut   = 1'b1;
                addressDataOut = r_dma_q;
                if (!busyIn) begin
                    w_word_acc = 1'b1;
                    if (r_burst_left == 9'd1) begin
                        w_state_next = S_WAIT_END;
                    end
                end
            end
            S_WAIT_END: begin
                endTransactionOut = 1'b1;
                w_burst_end       = 1'b1;
                w_state_next      = (r_remaining == 10'd0) ? S_DONE : S_REQUEST;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_next = S_IDLE;
            w_dma_we     = 1'b0;
            w_word_acc   = 1'b0;
            w_burst_end  = 1'b0;
        end
    end

    // CI register file, status and DMA working counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_done         <= 1'b0;
            r_is_mem       <= 1'b0;
            r_cfg_q        <= 32'd0;
            r_bus_addr_cfg <= 32'd0;
            r_mem_addr_cfg <= 9'd0;
            r_size_cfg     <= 10'd0;
            r_burst_cfg    <= 8'd0;
            r_bus_addr     <= 32'd0;
            r_sram_addr    <= 9'd0;
            r_remaining    <= 10'd0;
            r_burst        <= 8'd0;
            r_burst_left   <= 9'd0;
            r_burst_words  <= 9'd0;
            r_dir_read     <= 1'b0;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_done <= w_accept;
            if (w_accept) begin
                r_is_mem <= (w_func == c_FN_SRAM);
                case (w_func)
                    c_FN_BUSADDR: r_cfg_q <= r_bus_addr_cfg;
                    c_FN_MEMADDR: r_cfg_q <= {23'd0, r_mem_addr_cfg};
                    c_FN_SIZE:    r_cfg_q <= {22'd0, r_size_cfg};
                    c_FN_BURST:   r_cfg_q <= {24'd0, r_burst_cfg};
                    c_FN_CTRL:    r_cfg_q <= {30'd0, r_error, r_busy};
                    default:      r_cfg_q <= 32'd0;
                endcase
            end
            if (w_cfg_we) begin
                case (w_func)
                    c_FN_BUSADDR: r_bus_addr_cfg <= valueB;
                    c_FN_MEMADDR: r_mem_addr_cfg <= valueB[8:0];
                    c_FN_SIZE:    r_size_cfg     <= valueB[9:0];
                    c_FN_BURST:   r_burst_cfg    <= valueB[7:0];
                    default:      ;
                endcase
            end
            if (w_abort) begin
                r_busy  <= 1'b0;
                r_error <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_dma) begin
                            r_bus_addr  <= r_bus_addr_cfg;
                            r_sram_addr <= r_mem_addr_cfg;
                            r_remaining <= r_size_cfg;
                            r_burst     <= r_burst_cfg;
                            r_dir_read  <= (valueB[1:0] == 2'd1);
                            r_busy      <= 1'b1;
                            r_error     <= 1'b0;
                        end
                    end
                    S_INIT: begin
                        r_burst_left  <= w_burst_words;
                        r_burst_words <= w_burst_words;
                    end
                    S_READ: begin
                        if (dataValidIn) begin
                            r_sram_addr <= r_sram_addr + 9'd1;
                            r_remaining <= r_remaining - 10'd1;
                        end
                        if (w_burst_end) begin
                            r_bus_addr <= r_bus_addr + {21'd0, r_burst_words, 2'b00};
                        end
                    end
                    S_WRITE: begin
                        if (w_word_acc) begin
                            r_sram_addr  <= r_sram_addr + 9'd1;
                            r_remaining  <= r_remaining - 10'd1;
                            r_burst_left <= r_burst_left - 9'd1;
                        end
                    end
                    S_WAIT_END: begin
                        r_bus_addr <= r_bus_addr + {21'd0, r_burst_words, 2'b00};
                    end
                    S_DONE: begin
                        r_busy <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_dma_ci.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ram_dma_ci
// Description : Self-checking bench for ram_dma_ci (CI scoreboard + bus model)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_dma_ci;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  ciN = 8'd0;
    logic [31:0] valueA = 32'd0;
    logic [31:0] valueB = 32'd0;
    logic        done;
    logic [31:0] result;
    logic        requestTransaction;
    logic        transactionGranted = 1'b0;
    logic [31:0] addressDataIn = 32'd0;
    logic        dataValidIn = 1'b0;
    logic        endTransactionIn = 1'b0;
    logic        busErrorIn = 1'b0;
    logic        busyIn = 1'b0;
    logic [31:0] addressDataOut;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;
    logic        readNotWriteOut;
    logic        beginTransactionOut;
    logic        endTransactionOut;
    logic        dataValidOut;

    ram_dma_ci #(.customId(8'd15)) u_dut (
        .clock(clock), .reset(reset), .start(start), .ciN(ciN),
        .valueA(valueA), .valueB(valueB), .done(done), .result(result),
        .requestTransaction(requestTransaction), .transactionGranted(transactionGranted),
        .addressDataIn(addressDataIn), .dataValidIn(dataValidIn),
        .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn), .busyIn(busyIn),
        .addressDataOut(addressDataOut), .byteEnablesOut(byteEnablesOut),
        .burstSizeOut(burstSizeOut), .readNotWriteOut(readNotWriteOut),
        .beginTransactionOut(beginTransactionOut), .endTransactionOut(endTransactionOut),
        .dataValidOut(dataValidOut)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        bit          chk;
        logic [31:0] val;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        r_pop;
    logic [31:0] bq[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // CI scoreboard: every done pops one expected response
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("ci_unexpected_done", 32'd1, 32'd0);
            end else begin
                r_pop = sb.pop_front();
                check_val({r_pop.tag, "_latency"}, cyc, r_pop.cyc);
                if (r_pop.chk) check_val(r_pop.tag, result, r_pop.val);
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic ci_set(input logic [2:0] f, input bit we, input logic [8:0] a,
                          input logic [31:0] d, input bit chk, input logic [31:0] ev,
                          input string tag);
        exp_t e;
        start  = 1'b1;
        ciN    = 8'd15;
        valueA = {19'd0, f, we, a};
        valueB = d;
        e.chk = chk; e.val = ev; e.cyc = cyc + 1; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic ci(input logic [2:0] f, input bit we, input logic [8:0] a,
                      input logic [31:0] d, input bit chk, input logic [31:0] ev,
                      input string tag);
        tick;
        ci_set(f, we, a, d, chk, ev, tag);
        tick;
        start  = 1'b0;
        valueA = 32'd0;
        valueB = 32'd0;
    endtask

    task automatic wait_req(input string tag);
        int g = 0;
        while (requestTransaction !== 1'b1 && g < 40) begin
            tick;
            g++;
        end
        check_val({tag, "_req"}, {31'd0, requestTransaction}, 32'd1);
    endtask

    task automatic do_grant(input int nwait);
        repeat (nwait) tick;
        transactionGranted = 1'b1;
        tick;
        transactionGranted = 1'b0;
    endtask

    task automatic check_begin(input string tag, input logic [31:0] addr,
                               input logic [7:0] bs, input bit rnw);
        check_val({tag, "_begin"}, {31'd0, beginTransactionOut}, 32'd1);
        check_val({tag, "_addr"}, addressDataOut, addr);
        check_val({tag, "_be_bs_rnw"}, {19'd0, byteEnablesOut, burstSizeOut, readNotWriteOut},
                  {19'd0, 4'hF, bs, rnw});
        check_val({tag, "_req_low"}, {31'd0, requestTransaction}, 32'd0);
    endtask

    task automatic feed_read(input logic [31:0] base, input int n);
        tick;
        for (int i = 0; i < n; i++) begin
            dataValidIn   = 1'b1;
            addressDataIn = base + 32'(10 * i);
            tick;
        end
        dataValidIn      = 1'b0;
        addressDataIn    = 32'd0;
        endTransactionIn = 1'b1;
        tick;
        endTransactionIn = 1'b0;
    endtask

    // Slave side of a write burst; stall window is [stall_lo, stall_lo+3)
    task automatic write_burst(input string tag, input int n, input int stall_lo);
        int acc = 0;
        int g   = 0;
        while (acc < n && g < 30) begin
            busyIn = (g >= stall_lo) && (g < stall_lo + 3);
            check_val({tag, "_dvo"}, {31'd0, dataValidOut}, 32'd1);
            if (bq.size() > 0) check_val({tag, "_data"}, addressDataOut, bq[0]);
            else check_val({tag, "_extra_word"}, 32'd1, 32'd0);
            if (!busyIn && bq.size() > 0) begin
                void'(bq.pop_front());
                acc++;
            end
            tick;
            g++;
        end
        busyIn = 1'b0;
        check_val({tag, "_words"}, acc, n);
        check_val({tag, "_end"}, {30'd0, endTransactionOut, dataValidOut}, 32'd2);
    endtask

    task automatic check_all_zero(input string tag, input bit with_ci);
        check_val({tag, "_ctl"}, {26'd0, requestTransaction, readNotWriteOut,
                  beginTransactionOut, endTransactionOut, dataValidOut,
                  with_ci ? done : 1'b0}, 32'd0);
        check_val({tag, "_addr"}, addressDataOut, 32'd0);
        check_val({tag, "_be_bs"}, {20'd0, byteEnablesOut, burstSizeOut}, 32'd0);
        if (with_ci) check_val({tag, "_result"}, result, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick;
        tick;
        check_all_zero("reset", 1'b1);
        reset = 1'b1;

        // Config write then back-to-back readback
        ci(3'd1, 1'b1, 9'd0, 32'd55, 1'b0, 32'd0, "wr_busaddr");
        ci(3'd2, 1'b1, 9'd0, 32'd0,  1'b0, 32'd0, "wr_memaddr");
        ci(3'd3, 1'b1, 9'd0, 32'd6,  1'b0, 32'd0, "wr_size");
        ci(3'd4, 1'b1, 9'd0, 32'd2,  1'b0, 32'd0, "wr_burst");
        tick;
        ci_set(3'd1, 1'b0, 9'd0, 32'd0, 1'b1, 32'd55, "rd_busaddr"); tick;
        ci_set(3'd2, 1'b0, 9'd0, 32'd0, 1'b1, 32'd0,  "rd_memaddr"); tick;
        ci_set(3'd3, 1'b0, 9'd0, 32'd0, 1'b1, 32'd6,  "rd_size");    tick;
        ci_set(3'd4, 1'b0, 9'd0, 32'd0, 1'b1, 32'd2,  "rd_burst");   tick;
        ci_set(3'd6, 1'b0, 9'd0, 32'd0, 1'b1, 32'd0,  "rd_func6");   tick;
        start = 1'b0;
        // Foreign CI number must not respond
        tick;
        start = 1'b1; ciN = 8'd3; valueA = {19'd0, 3'd1, 1'b0, 9'd0};
        tick;
        start = 1'b0; ciN = 8'd0; valueA = 32'd0;

        // Read DMA: two bursts of three words
        ci(3'd5, 1'b1, 9'd0, 32'd1, 1'b0, 32'd0, "ctrl_rd");
        wait_req("rd1");
        ci(3'd1, 1'b1, 9'd0, 32'd999, 1'b0, 32'd0, "wr_busy_ignored");
        do_grant(0);
        check_begin("rd1", 32'd55, 8'd2, 1'b1);
        feed_read(32'd10, 3);
        wait_req("rd2");
        do_grant(2);
        check_begin("rd2", 32'd67, 8'd2, 1'b1);
        feed_read(32'd40, 3);
        tick;
        ci(3'd5, 1'b0, 9'd0, 32'd0, 1'b1, 32'd0, "status_after_rd");
        ci(3'd1, 1'b0, 9'd0, 32'd0, 1'b1, 32'd55, "busaddr_kept");
        for (int i = 0; i < 6; i++) begin
            ci(3'd0, 1'b0, 9'(i), 32'd0, 1'b1, 32'(10 * (i + 1)), "sram_rd");
        end

        // Write DMA: bursts of 3 (with a 3-cycle stall) and 2
        ci(3'd1, 1'b1, 9'd0, 32'd13, 1'b0, 32'd0, "wr_busaddr2");
        ci(3'd3, 1'b1, 9'd0, 32'd5,  1'b0, 32'd0, "wr_size2");
        bq = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50};
        ci(3'd5, 1'b1, 9'd0, 32'd2, 1'b0, 32'd0, "ctrl_wr");
        wait_req("wr1");
        do_grant(2);
        check_begin("wr1", 32'd13, 8'd2, 1'b0);
        tick;
        write_burst("wr1", 3, 1);
        tick;
        wait_req("wr2");
        do_grant(1);
        check_begin("wr2", 32'd25, 8'd1, 1'b0);
        tick;
        write_burst("wr2", 2, 100);
        tick;
        tick;
        ci(3'd5, 1'b0, 9'd0, 32'd0, 1'b1, 32'd0, "status_after_wr");

        // Bus error in the middle of a read burst
        ci(3'd1, 1'b1, 9'd0, 32'd100, 1'b0, 32'd0, "wr_busaddr3");
        ci(3'd2, 1'b1, 9'd0, 32'd10,  1'b0, 32'd0, "wr_memaddr3");
        ci(3'd3, 1'b1, 9'd0, 32'd4,   1'b0, 32'd0, "wr_size3");
        ci(3'd4, 1'b1, 9'd0, 32'd3,   1'b0, 32'd0, "wr_burst3");
        ci(3'd5, 1'b1, 9'd0, 32'd1,   1'b0, 32'd0, "ctrl_rd_err");
        wait_req("err");
        do_grant(0);
        check_begin("err", 32'd100, 8'd3, 1'b1);
        tick;
        dataValidIn = 1'b1; addressDataIn = 32'd77;
        tick;
        dataValidIn = 1'b0; addressDataIn = 32'd0; busErrorIn = 1'b1;
        tick;
        busErrorIn = 1'b0;
        check_all_zero("err_bus", 1'b0);
        ci(3'd5, 1'b0, 9'd0, 32'd0, 1'b1, 32'd2, "status_err");
        ci(3'd0, 1'b0, 9'd10, 32'd0, 1'b1, 32'd77, "sram_err_word");

        // Zero-length block: no bus request, status returns to idle
        ci(3'd3, 1'b1, 9'd0, 32'd0, 1'b0, 32'd0, "wr_size0");
        ci(3'd5, 1'b1, 9'd0, 32'd1, 1'b0, 32'd0, "ctrl_size0");
        begin
            int seen = 0;
            repeat (5) begin
                if (requestTransaction !== 1'b0) seen++;
                tick;
            end
            check_val("size0_no_request", seen, 0);
        end
        ci(3'd5, 1'b0, 9'd0, 32'd0, 1'b1, 32'd0, "status_size0");

        // Reset in the middle of a write burst
        ci(3'd1, 1'b1, 9'd0, 32'd13, 1'b0, 32'd0, "wr_busaddr4");
        ci(3'd2, 1'b1, 9'd0, 32'd0,  1'b0, 32'd0, "wr_memaddr4");
        ci(3'd3, 1'b1, 9'd0, 32'd5,  1'b0, 32'd0, "wr_size4");
        ci(3'd4, 1'b1, 9'd0, 32'd2,  1'b0, 32'd0, "wr_burst4");
        ci(3'd5, 1'b1, 9'd0, 32'd2,  1'b0, 32'd0, "ctrl_wr_rst");
        wait_req("rst");
        do_grant(0);
        tick;
        check_val("rst_pre_dvo", {31'd0, dataValidOut}, 32'd1);
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid", 1'b1);
        tick;
        tick;
        reset = 1'b1;
        ci(3'd5, 1'b0, 9'd0, 32'd0, 1'b1, 32'd0, "status_after_rst");
        ci(3'd0, 1'b0, 9'd3, 32'd0, 1'b1, 32'd40, "sram_kept_rst");

        tick;
        tick;
        check_val("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
